tft_spi_tx: RTL and testbench
=============================

Name: tft_spi_tx

Overview:
Byte-level transmitter on the display side of the tft_transmit/tft_dc/tft_data/tft_busy handshake used by the drawing blocks (player, maze renderer).
Accepts one byte plus its D/C flag per handshake and serialises it onto the panel's 4-wire SPI bus: SCK, MOSI, CS_n, D/C, mode 0, MSB first.
Sits between the draw-arbiter output and the top-level TFT pins.
Buffers only one byte; it has no FIFO.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period; legal range >= 1.
CS_GAP, 1, clk cycles CS_n is held high after each byte before busy drops; legal range >= 1.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
tft_transmit  input  1  request: initiator presents a byte.
tft_dc  input  1  0 = command byte, 1 = data byte.
tft_data  input  8  byte to send.
tft_busy  output  1  high from the cycle after acceptance until the byte and CS gap complete.
spi_sck  output  1  SPI clock, idles low.
spi_mosi  output  1  serial data, MSB first.
spi_cs_n  output  1  chip select, active low, framed per byte.
spi_dc  output  1  D/C pin, registered copy of the accepted tft_dc.

Behaviour:
- Reset (rst=1 at clk edge): tft_busy=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, state=IDLE, counters=0.
  - Reset mid-byte aborts the transfer; CS_n is high on the next cycle; no partial-byte recovery.
- Acceptance rule: tft_transmit=1 AND tft_busy=0 sampled at an edge (edge 0).
  - tft_data and tft_dc are latched at edge 0; later changes are ignored until the next acceptance.
- Requests while busy are ignored and not queued.
- Level-sensitive: if tft_transmit is still high on the first cycle tft_busy=0, a new byte is accepted.
  - The initiator must drop tft_transmit once it sees busy.
  - Minimum busy width (17*CLK_DIV+CS_GAP >= 18 cycles) guarantees the initiator sees busy.
- States: IDLE -> LOW -> HIGH -> (LOW ... x8 bits) -> HOLD -> GAP -> IDLE.
  - IDLE: sck=0, cs_n=1, busy=0.
  - On acceptance, after edge 0: busy=1, cs_n=0, spi_dc=latched dc, mosi=bit7, sck=0. Enter LOW, bit index=7.
  - LOW: sck=0 for CLK_DIV cycles, mosi stable = current bit. Then go to HIGH.
  - HIGH: sck=1 for CLK_DIV cycles. Then:
    - if bit index>0: decrement, load the next bit onto mosi with sck falling, go to LOW.
    - otherwise: go to HOLD.
  - HOLD: sck=0, cs_n=0, mosi unchanged, for CLK_DIV cycles. Then cs_n=1, go to GAP.
  - GAP: cs_n=1, busy=1 for CS_GAP cycles. Then busy=0, go to IDLE.
- Timing: tft_busy is high for exactly 17*CLK_DIV+CS_GAP cycles (35 with defaults), from the cycle after edge 0.
- MOSI changes only while SCK is low; the receiver samples on the SCK rising edge.
- spi_dc stays valid for the whole CS_n-low window. It keeps its value after CS_n rises until the next acceptance.
- Half-period counter width is $clog2(CLK_DIV+1); GAP counter width is $clog2(CS_GAP+1). Neither counter wraps: both reload on every phase entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package tft_pkg holds:
  - state enum (IDLE, LOW, HIGH, HOLD, GAP);
  - command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C, for use by initiators and benches.
- Single flat module; no sub-module needed.
- The bench uses a separate SPI monitor, spi_mode0_sniffer, which samples MOSI on SCK rise and emits {dc, byte} when CS_n rises.

Test Plan:
1. Single command: CLK_DIV=2, CS_GAP=1, send tft_dc=0, tft_data=8'h2A.
   -> MOSI sampled on rises = 0,0,1,0,1,0,1,0; spi_dc=0 while CS_n is low; busy high exactly 35 cycles; 8 SCK rising edges.
2. Ignored request: send data byte 8'hA5 (dc=1); at cycle 5 pulse tft_transmit with 8'h3C.
   -> sniffer reports only {1,A5}; busy width is unchanged.
3. Initiator-style back-to-back: stream 11 bytes (2A,00,10,00,19,2A,00,20,00,29,2C) with a player-like FSM that drops transmit on busy.
   -> sniffer reports the same 11 bytes in order, with dc pattern 0,1,1,1,1,0,1,1,1,1,0; no duplicates.
4. Held request: keep tft_transmit=1 continuously with 8'hFF, dc=1.
   -> a new byte is accepted on each busy-low cycle; exactly one IDLE cycle between bytes; CS_n is high at least CS_GAP cycles between frames.
5. Reset mid-byte: assert rst at cycle 10 of a 8'h81 transfer.
   -> on the next cycle CS_n=1, sck=0, busy=0, mosi=0; a subsequent byte 8'h55 transfers correctly.
6. CLK_DIV=1, CS_GAP=3, byte 8'h00 then 8'hFF.
   -> SCK period is 2 clk cycles; busy width is 20 cycles; MOSI is constant per byte; spi_dc follows each byte.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT byte transmitter and its initiators.
package tft_pkg;

  // Transmitter phase: one byte walks IDLE -> (LOW, HIGH) x8 -> HOLD -> GAP -> IDLE
  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  // Panel command opcodes used by the drawing blocks
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/tft_spi_tx_if.sv
// Byte handshake between a drawing-block initiator and the TFT SPI transmitter.
interface tft_spi_tx_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (output tft_transmit, tft_dc, tft_data, input tft_busy);
  modport slave  (input tft_transmit, tft_dc, tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx.sv
// Single-byte SPI mode-0 transmitter for the TFT panel: MSB first, CS_n framed
// per byte, D/C held for the whole frame. No FIFO; one byte in flight.
module tft_spi_tx
  import tft_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  tft_spi_tx_if.slave  tft,
  output logic         spi_sck,
  output logic         spi_mosi,
  output logic         spi_cs_n,
  output logic         spi_dc
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  // Counters reload on every phase entry and count down to zero
  localparam logic [HW-1:0] H_LD = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LD = GW'(CS_GAP - 1);

  state_t        state;
  logic          busy;
  logic [HW-1:0] hcnt;
  logic [GW-1:0] gcnt;
  logic [2:0]    bidx;
  logic [6:0]    sh;    // remaining bits after the one on mosi, MSB next

  assign tft.tft_busy = busy;

  // Phase sequencer; every pin is a register so nothing flows input->output combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_dc   <= 1'b0;
      hcnt     <= '0;
      gcnt     <= '0;
      bidx     <= '0;
      sh       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tft.tft_transmit && !busy) begin
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_dc   <= tft.tft_dc;
            spi_mosi <= tft.tft_data[7];
            sh       <= tft.tft_data[6:0];
            spi_sck  <= 1'b0;
            bidx     <= 3'd7;
            hcnt     <= H_LD;
            state    <= LOW;
          end
        end
        LOW: begin
          if (hcnt == '0) begin
            spi_sck <= 1'b1;
            hcnt    <= H_LD;
            state   <= HIGH;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        HIGH: begin
          if (hcnt == '0) begin
            spi_sck <= 1'b0;
            hcnt    <= H_LD;
            if (bidx != 3'd0) begin
              // next bit goes out together with the falling SCK edge
              bidx     <= bidx - 3'd1;
              spi_mosi <= sh[6];
              sh       <= {sh[5:0], 1'b0};
              state    <= LOW;
            end else begin
              state <= HOLD;
            end
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        HOLD: begin
          if (hcnt == '0) begin
            spi_cs_n <= 1'b1;
            gcnt     <= G_LD;
            state    <= GAP;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        GAP: begin
          if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: two instances (CLK_DIV=2/CS_GAP=1 and CLK_DIV=1/CS_GAP=3),
// an SPI mode-0 sniffer per instance, and per-scenario tasks.
module tb_tft_spi_tx;
  import tft_pkg::*;

  localparam int D0 = 2, G0 = 1, D1 = 1, G1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx[2]   = '{1'b0, 1'b0};
  logic       dcin[2] = '{1'b0, 1'b0};
  logic [7:0] din[2]  = '{8'h00, 8'h00};
  wire        busy[2], sck[2], mosi[2], csn[2], sdc[2];

  tft_spi_tx_if bus0 ();
  tft_spi_tx_if bus1 ();
  assign bus0.tft_transmit = tx[0];
  assign bus0.tft_dc       = dcin[0];
  assign bus0.tft_data     = din[0];
  assign busy[0]           = bus0.tft_busy;
  assign bus1.tft_transmit = tx[1];
  assign bus1.tft_dc       = dcin[1];
  assign bus1.tft_data     = din[1];
  assign busy[1]           = bus1.tft_busy;

  tft_spi_tx #(.CLK_DIV(D0), .CS_GAP(G0)) dut0 (
    .clk(clk), .rst(rst), .tft(bus0),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_cs_n(csn[0]), .spi_dc(sdc[0]));
  tft_spi_tx #(.CLK_DIV(D1), .CS_GAP(G1)) dut1 (
    .clk(clk), .rst(rst), .tft(bus1),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_cs_n(csn[1]), .spi_dc(sdc[1]));

  int total = 0;
  int bad   = 0;

  function automatic int dv(input int u);
    return (u == 0) ? D0 : D1;
  endfunction
  function automatic int gv(input int u);
    return (u == 0) ? G0 : G1;
  endfunction
  function automatic int bw(input int u);
    return 17 * dv(u) + gv(u);
  endfunction

  // spi_mode0_sniffer: samples MOSI on SCK rise, emits {dc, byte} when CS_n rises,
  // and flags protocol violations (MOSI moving while SCK high, D/C moving in frame,
  // SCK rise spacing other than 2*CLK_DIV).
  logic       sck_p[2] = '{1'b0, 1'b0};
  logic       mosi_p[2] = '{1'b0, 1'b0};
  logic       csn_p[2] = '{1'b1, 1'b1};
  logic       dc_p[2] = '{1'b0, 1'b0};
  logic [7:0] shr[2] = '{8'h00, 8'h00};
  int         nb[2] = '{0, 0};
  int         lastr[2] = '{-1, -1};
  int         rises[2] = '{0, 0};
  int         per_err[2] = '{0, 0};
  int         mosi_err[2] = '{0, 0};
  int         dc_err[2] = '{0, 0};
  logic [8:0] fr[2][128];
  int         fbits[2][128];
  int         nfr[2] = '{0, 0};
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (csn[u] === 1'b0 && csn_p[u] === 1'b1) begin
        shr[u] = 8'h00; nb[u] = 0; lastr[u] = -1;
      end
      if (sck[u] === 1'b1 && sck_p[u] === 1'b0) begin
        rises[u]++;
        if (csn[u] === 1'b0) begin
          shr[u] = {shr[u][6:0], mosi[u]};
          nb[u]++;
        end
        if (lastr[u] >= 0 && (cyc - lastr[u]) != 2 * dv(u)) per_err[u]++;
        lastr[u] = cyc;
      end
      if (sck[u] === 1'b1 && sck_p[u] === 1'b1 && mosi[u] !== mosi_p[u]) mosi_err[u]++;
      if (csn[u] === 1'b0 && csn_p[u] === 1'b0 && sdc[u] !== dc_p[u]) dc_err[u]++;
      if (csn[u] === 1'b1 && csn_p[u] === 1'b0 && nfr[u] < 128) begin
        fr[u][nfr[u]] = {sdc[u], shr[u]};
        fbits[u][nfr[u]] = nb[u];
        nfr[u]++;
      end
      sck_p[u] = sck[u]; mosi_p[u] = mosi[u]; csn_p[u] = csn[u]; dc_p[u] = sdc[u];
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Present one byte, drop the request after acceptance, count busy cycles
  task automatic send(input int u, input logic d, input logic [7:0] b, output int w);
    tx[u] = 1'b1; dcin[u] = d; din[u] = b;
    step;
    tx[u] = 1'b0; din[u] = 8'($urandom); dcin[u] = 1'($urandom);
    w = 0;
    while (busy[u] === 1'b1 && w < 400) begin
      w++;
      step;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    for (int u = 0; u < 2; u++) begin
      total += 5;
      if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d got=%b want=0", u, busy[u]); end
      if (sck[u] !== 1'b0) begin bad++; $display("FAIL reset_sck u%0d got=%b want=0", u, sck[u]); end
      if (mosi[u] !== 1'b0) begin bad++; $display("FAIL reset_mosi u%0d got=%b want=0", u, mosi[u]); end
      if (csn[u] !== 1'b1) begin bad++; $display("FAIL reset_csn u%0d got=%b want=1", u, csn[u]); end
      if (sdc[u] !== 1'b0) begin bad++; $display("FAIL reset_dc u%0d got=%b want=0", u, sdc[u]); end
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_single;
    int w, r, rs, pe, me, de;
    logic [8:0] exp_q[$];
    r = nfr[0]; rs = rises[0]; pe = per_err[0]; me = mosi_err[0]; de = dc_err[0];
    send(0, 1'b0, CMD_CASET, w);
    total += 7;
    if (w !== 35) begin bad++; $display("FAIL single_busy_width got=%0d want=35", w); end
    if (nfr[0] - r !== 1) begin bad++; $display("FAIL single_frames got=%0d want=1", nfr[0] - r); end
    if (fr[0][r] !== 9'h02A) begin bad++; $display("FAIL single_frame got=%h want=02a", fr[0][r]); end
    if (fbits[0][r] !== 8) begin bad++; $display("FAIL single_bits got=%0d want=8", fbits[0][r]); end
    if (rises[0] - rs !== 8) begin bad++; $display("FAIL single_rises got=%0d want=8", rises[0] - rs); end
    if (mosi_err[0] - me !== 0) begin bad++; $display("FAIL single_mosi_stable got=%0d want=0", mosi_err[0] - me); end
    if (dc_err[0] - de + per_err[0] - pe !== 0) begin
      bad++; $display("FAIL single_dc_period got=%0d want=0", dc_err[0] - de + per_err[0] - pe);
    end
    // random bytes against the {dc, byte} model
    r = nfr[0];
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b; logic d;
      b = 8'($urandom); d = 1'($urandom_range(0, 1));
      exp_q.push_back({d, b});
      send(0, d, b, w);
      total++;
      if (w !== bw(0)) begin bad++; $display("FAIL rand_width i%0d got=%0d want=%0d", i, w, bw(0)); end
    end
    total++;
    if (nfr[0] - r !== 6) begin bad++; $display("FAIL rand_frames got=%0d want=6", nfr[0] - r); end
    for (int i = 0; i < 6 && i < nfr[0] - r; i++) begin
      total++;
      if (fr[0][r+i] !== exp_q[i]) begin bad++; $display("FAIL rand_frame i%0d got=%h want=%h", i, fr[0][r+i], exp_q[i]); end
    end
  endtask

  task automatic test_ignored;
    int w, r;
    r = nfr[0];
    tx[0] = 1'b1; dcin[0] = 1'b1; din[0] = 8'hA5;
    step;
    tx[0] = 1'b0;
    w = 0;
    while (busy[0] === 1'b1 && w < 400) begin
      w++;
      if (w == 5) begin tx[0] = 1'b1; din[0] = 8'h3C; dcin[0] = 1'b0; end
      else tx[0] = 1'b0;
      step;
    end
    tx[0] = 1'b0;
    step; step;
    total += 4;
    if (w !== 35) begin bad++; $display("FAIL ignored_width got=%0d want=35", w); end
    if (nfr[0] - r !== 1) begin bad++; $display("FAIL ignored_frames got=%0d want=1", nfr[0] - r); end
    if (fr[0][r] !== 9'h1A5) begin bad++; $display("FAIL ignored_frame got=%h want=1a5", fr[0][r]); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL ignored_requeued got=%b want=0", busy[0]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bl[11] = '{8'h2A, 8'h00, 8'h10, 8'h00, 8'h19, 8'h2A, 8'h00, 8'h20, 8'h00, 8'h29, 8'h2C};
    logic [8:0] exp_q[$];
    int r, t, n;
    r = nfr[0];
    n = 0;
    for (int i = 0; i < 19; i++) begin
      logic [7:0] b; logic d;
      if (i < 11) begin b = bl[i]; d = !(i == 0 || i == 5 || i == 10); end
      else begin b = 8'($urandom); d = 1'($urandom_range(0, 1)); end
      exp_q.push_back({d, b});
      t = 0;
      while (busy[0] === 1'b1 && t < 400) begin t++; step; end
      tx[0] = 1'b1; din[0] = b; dcin[0] = d;
      t = 0;
      do begin step; t++; end while (busy[0] !== 1'b1 && t < 10);
      tx[0] = 1'b0;
      n++;
    end
    t = 0;
    while (busy[0] === 1'b1 && t < 400) begin t++; step; end
    step;
    total++;
    if (nfr[0] - r !== n) begin bad++; $display("FAIL b2b_frames got=%0d want=%0d", nfr[0] - r, n); end
    for (int i = 0; i < n && i < nfr[0] - r; i++) begin
      total++;
      if (fr[0][r+i] !== exp_q[i]) begin bad++; $display("FAIL b2b_frame i%0d got=%h want=%h", i, fr[0][r+i], exp_q[i]); end
    end
  endtask

  task automatic test_held;
    int r, nrise, lowrun, csrun, t;
    logic pb, pc, started_cs;
    r = nfr[0];
    nrise = 0; lowrun = 0; csrun = 0; pb = 1'b0; pc = 1'b1; started_cs = 1'b0;
    tx[0] = 1'b1; din[0] = 8'hFF; dcin[0] = 1'b1;
    t = 0;
    while (nrise < 4 && t < 600) begin
      step; t++;
      if (busy[0] === 1'b1 && pb === 1'b0) begin
        if (nrise > 0) begin
          total++;
          if (lowrun !== 1) begin bad++; $display("FAIL held_idle_gap got=%0d want=1", lowrun); end
        end
        nrise++;
        lowrun = 0;
      end
      if (busy[0] !== 1'b1) lowrun++;
      if (csn[0] === 1'b0 && pc === 1'b1) begin
        if (started_cs) begin
          total++;
          if (csrun < G0) begin bad++; $display("FAIL held_cs_gap got=%0d want>=%0d", csrun, G0); end
        end
        started_cs = 1'b1;
        csrun = 0;
      end
      if (csn[0] === 1'b1) csrun++;
      pb = busy[0]; pc = csn[0];
    end
    tx[0] = 1'b0;
    t = 0;
    while (busy[0] === 1'b1 && t < 400) begin t++; step; end
    step;
    total++;
    if (nfr[0] - r !== 4) begin bad++; $display("FAIL held_frames got=%0d want=4", nfr[0] - r); end
    for (int i = 0; i < 4 && i < nfr[0] - r; i++) begin
      total++;
      if (fr[0][r+i] !== 9'h1FF) begin bad++; $display("FAIL held_frame i%0d got=%h want=1ff", i, fr[0][r+i]); end
    end
  endtask

  task automatic test_reset_mid;
    int w, r;
    tx[0] = 1'b1; din[0] = 8'h81; dcin[0] = 1'b0;
    step;
    tx[0] = 1'b0;
    repeat (9) step;
    rst = 1'b1;
    step;
    total += 4;
    if (csn[0] !== 1'b1) begin bad++; $display("FAIL midrst_csn got=%b want=1", csn[0]); end
    if (sck[0] !== 1'b0) begin bad++; $display("FAIL midrst_sck got=%b want=0", sck[0]); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy[0]); end
    if (mosi[0] !== 1'b0) begin bad++; $display("FAIL midrst_mosi got=%b want=0", mosi[0]); end
    rst = 1'b0;
    step;
    r = nfr[0];
    send(0, 1'b1, 8'h55, w);
    total += 3;
    if (w !== 35) begin bad++; $display("FAIL midrst_width got=%0d want=35", w); end
    if (nfr[0] - r !== 1) begin bad++; $display("FAIL midrst_frames got=%0d want=1", nfr[0] - r); end
    if (fr[0][r] !== 9'h155) begin bad++; $display("FAIL midrst_frame got=%h want=155", fr[0][r]); end
  endtask

  task automatic test_div1;
    logic [7:0] bl[6];
    logic       dl[6];
    int w, r, rs, pe, me;
    bl[0] = 8'h00; dl[0] = 1'b0;
    bl[1] = 8'hFF; dl[1] = 1'b1;
    for (int i = 2; i < 6; i++) begin bl[i] = 8'($urandom); dl[i] = 1'($urandom_range(0, 1)); end
    r = nfr[1]; rs = rises[1]; pe = per_err[1]; me = mosi_err[1];
    for (int i = 0; i < 6; i++) begin
      send(1, dl[i], bl[i], w);
      total += 2;
      if (w !== 20) begin bad++; $display("FAIL div1_width i%0d got=%0d want=20", i, w); end
      if (sdc[1] !== dl[i]) begin bad++; $display("FAIL div1_dc_hold i%0d got=%b want=%b", i, sdc[1], dl[i]); end
    end
    total += 4;
    if (nfr[1] - r !== 6) begin bad++; $display("FAIL div1_frames got=%0d want=6", nfr[1] - r); end
    if (rises[1] - rs !== 48) begin bad++; $display("FAIL div1_rises got=%0d want=48", rises[1] - rs); end
    if (per_err[1] - pe !== 0) begin bad++; $display("FAIL div1_sck_period got=%0d want=0", per_err[1] - pe); end
    if (mosi_err[1] - me !== 0) begin bad++; $display("FAIL div1_mosi_stable got=%0d want=0", mosi_err[1] - me); end
    for (int i = 0; i < 6 && i < nfr[1] - r; i++) begin
      total++;
      if (fr[1][r+i] !== {dl[i], bl[i]}) begin bad++; $display("FAIL div1_frame i%0d got=%h want=%h", i, fr[1][r+i], {dl[i], bl[i]}); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_ignored;
    test_back_to_back;
    test_held;
    test_reset_mid;
    test_div1;
    total++;
    if (dc_err[0] + dc_err[1] + mosi_err[0] + per_err[0] !== 0) begin
      bad++; $display("FAIL protocol_totals got=%0d want=0", dc_err[0] + dc_err[1] + mosi_err[0] + per_err[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
